// File: rtl/column_packer.sv
// Column packer: compacts the mask-selected byte lanes of each input beat into
// dense output words of BYTES lanes. A row is a run of beats ending with
// in_last. The final word of a row is flagged with out_last and may be
// partial. Its valid lanes are always contiguous from lane 0.
//
// Ports:
//   clk, reset         - single clock, asynchronous active-high reset
//   in_valid/in_ready  - input beat handshake
//   in_data            - beat bytes, lane i = bits [8i+7:8i]
//   in_mask            - lane select, bit i selects lane i
//   in_amount          - popcount of in_mask from upstream, used for the level update
//   in_last            - final beat of the row
//   out_valid/out_ready- output word handshake
//   out_data, out_keep - packed bytes and contiguous valid-lane mask
//   out_last           - final word of the row
//   mismatch_err       - sticky flag, set when in_amount disagrees with in_mask
module column_packer #(
  parameter int unsigned BYTES      = 8,
  parameter int unsigned COUNT_SIZE = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*BYTES-1:0]    in_data,
  input  logic [BYTES-1:0]      in_mask,
  input  logic [COUNT_SIZE-1:0] in_amount,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*BYTES-1:0]    out_data,
  output logic [BYTES-1:0]      out_keep,
  output logic                  out_last,
  output logic                  mismatch_err
);

  localparam int unsigned LvlW = $clog2(2 * BYTES);
  localparam int unsigned SumW = LvlW + 1;
  localparam int unsigned IdxW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned BufW = 16 * BYTES;
  localparam logic [SumW-1:0] BytesS = SumW'(BYTES);

  typedef enum logic [0:0] {StAccept, StFlush} state_e;

  state_e              state_q, state_d;
  logic [LvlW-1:0]     lvl_q, lvl_d;
  logic [BufW-1:0]     buf_q, buf_d;
  logic                err_q, err_d;

  logic [SumW-1:0]     lvl_s;
  logic [SumW-1:0]     amt_s;
  logic [SumW-1:0]     lvl_post;
  logic [BufW-1:0]     buf_post;
  logic [BufW-1:0]     ins_data;
  logic [2*BYTES-1:0]  ins_mask;
  logic [BYTES-1:0][7:0] lane_pack;
  logic [IdxW-1:0]     idx;
  int unsigned         pop_cnt;
  logic                pop, push;

  assign lvl_s = {1'b0, lvl_q};

  // An over-range amount is clamped so the level can never leave 0..2*BYTES-1.
  assign amt_s = (32'(in_amount) > BYTES) ? BytesS : SumW'(in_amount);

  assign mismatch_err = err_q;

  // Handshake and output word, all derived from registered state.
  always_comb begin
    out_keep  = '0;
    out_data  = '0;
    out_valid = (lvl_s >= BytesS) || (state_q == StFlush);
    in_ready  = (state_q == StAccept) && ((lvl_s < BytesS) || out_ready);
    out_last  = (state_q == StFlush) && (lvl_s <= BytesS);
    for (int i = 0; i < BYTES; i++) begin
      out_keep[i]        = lvl_s > SumW'(i);
      out_data[8*i +: 8] = out_keep[i] ? buf_q[8*i +: 8] : 8'h00;
    end
  end

  // Compact selected lanes to the bottom in ascending lane order.
  always_comb begin
    lane_pack = '0;
    idx       = '0;
    pop_cnt   = 0;
    for (int i = 0; i < BYTES; i++) begin
      if (in_mask[i]) begin
        lane_pack[idx] = in_data[8*i +: 8];
        idx            = idx + IdxW'(1);
        pop_cnt        = pop_cnt + 1;
      end
    end
  end

  // Next state: pop first, then append at the post-pop level.
  always_comb begin
    pop      = out_valid && out_ready;
    push     = in_valid && in_ready;
    buf_post = buf_q;
    lvl_post = lvl_s;
    if (pop) begin
      if (out_last) begin
        buf_post = '0;
        lvl_post = '0;
      end else begin
        buf_post = buf_q >> (8 * BYTES);
        lvl_post = (lvl_s > BytesS) ? (lvl_s - BytesS) : '0;
      end
    end

    ins_data = BufW'(lane_pack) << {lvl_post, 3'b000};
    ins_mask = ~({(2*BYTES){1'b1}} << amt_s) << lvl_post;

    buf_d = buf_post;
    lvl_d = LvlW'(lvl_post);
    if (push) begin
      for (int p = 0; p < 2 * BYTES; p++) begin
        if (ins_mask[p]) begin
          buf_d[8*p +: 8] = ins_data[8*p +: 8];
        end
      end
      lvl_d = LvlW'(lvl_post + amt_s);
    end

    state_d = state_q;
    unique case (state_q)
      StAccept: if (push && in_last) state_d = StFlush;
      StFlush:  if (pop && out_last) state_d = StAccept;
    endcase

    err_d = err_q | (push && (32'(in_amount) != pop_cnt));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StAccept;
      lvl_q   <= '0;
      buf_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_column_packer.sv
// Testbench for column_packer (BYTES=8): cycle-level vector table for the
// basic row shapes, hand sequences for backpressure / error / reset, and a
// randomized run checked against a byte-queue row model.
module tb_column_packer;

  localparam int unsigned BYTES = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [7:0]  in_mask;
  logic [3:0]  in_amount;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [7:0]  out_keep;
  logic        out_last;
  logic        mismatch_err;

  column_packer #(
    .BYTES(BYTES),
    .COUNT_SIZE(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_mask(in_mask),
    .in_amount(in_amount),
    .in_last(in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_keep(out_keep),
    .out_last(out_last),
    .mismatch_err(mismatch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } word_t;

  typedef struct {
    logic        iv;
    logic [63:0] d;
    logic [7:0]  m;
    logic [3:0]  a;
    logic        l;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [63:0] e_d;
    logic [7:0]  e_k;
    logic        e_l;
  } vec_t;

  word_t      exp_q[$];
  logic [7:0] byte_q[$];
  vec_t       vt[$];

  int total;
  int bad;

  logic        s_ir, s_ov, s_ol, s_err;
  logic [63:0] s_d;
  logic [7:0]  s_k;
  logic        hold_prev;
  logic [63:0] prev_d;
  logic [7:0]  prev_k;
  logic        prev_l;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Row model: bytes of the current row wait in byte_q; whole words leave as
  // soon as 8 bytes exist, the row's tail leaves on the last beat.
  task automatic emit(input int n, input logic last);
    word_t w;
    w.data = '0;
    w.keep = '0;
    w.last = last;
    for (int i = 0; i < n; i++) begin
      w.data[8*i +: 8] = byte_q.pop_front();
      w.keep[i]        = 1'b1;
    end
    exp_q.push_back(w);
  endtask

  task automatic model_push(input logic [63:0] d, input logic [7:0] m, input logic l);
    for (int i = 0; i < 8; i++) begin
      if (m[i]) byte_q.push_back(d[8*i +: 8]);
    end
    if (!l) begin
      if (byte_q.size() >= 8) emit(8, 1'b0);
    end else if (byte_q.size() == 0) begin
      emit(0, 1'b1);
    end else begin
      while (byte_q.size() > 8) emit(8, 1'b0);
      emit(byte_q.size(), 1'b1);
    end
  endtask

  task automatic sb_pop();
    word_t w;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_word: got data=%h keep=%h last=%b expected none", s_d, s_k, s_ol);
    end else begin
      w = exp_q.pop_front();
      check("word_data", s_d, w.data);
      check("word_keep", s_k, w.keep);
      check("word_last", s_ol, w.last);
    end
  endtask

  // One clock: drive after the falling edge, sample 1ns later, then wait for
  // the rising edge that acts on what was sampled.
  task automatic cycle(input logic iv, input logic [63:0] d, input logic [7:0] m,
                       input logic [3:0] a, input logic l, input logic ordy, input bit mdl);
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    in_mask   = m;
    in_amount = a;
    in_last   = l;
    out_ready = ordy;
    #1;
    s_ir  = in_ready;
    s_ov  = out_valid;
    s_d   = out_data;
    s_k   = out_keep;
    s_ol  = out_last;
    s_err = mismatch_err;
    if (hold_prev) begin
      check("hold_valid", s_ov, 1);
      check("hold_data", s_d, prev_d);
      check("hold_keep", s_k, prev_k);
      check("hold_last", s_ol, prev_l);
    end
    hold_prev = s_ov && !ordy;
    prev_d    = s_d;
    prev_k    = s_k;
    prev_l    = s_ol;
    if (iv && s_ir && mdl) model_push(d, m, l);
    if (s_ov && ordy) sb_pop();
    @(posedge clk);
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 64'h0, 8'h00, 4'd0, 1'b0, ordy, 1'b1);
  endtask

  function automatic vec_t mk(input logic iv, input logic [63:0] d, input logic [7:0] m,
                              input logic [3:0] a, input logic l, input logic e_ir,
                              input logic e_ov, input logic [63:0] e_d, input logic [7:0] e_k,
                              input logic e_l);
    vec_t v;
    v.iv = iv; v.d = d; v.m = m; v.a = a; v.l = l; v.ordy = 1'b1;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_d = e_d; v.e_k = e_k; v.e_l = e_l;
    return v;
  endfunction

  initial begin
    logic [63:0] bd;
    logic [7:0]  bm;
    bit          acc;
    int          tries;

    total     = 0;
    bad       = 0;
    hold_prev = 1'b0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mask   = '0;
    in_amount = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #1 reset = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_keep", out_keep, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_mismatch", mismatch_err, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Full masks, three beats.
    vt.push_back(mk(1, 64'hA7A6A5A4A3A2A1A0, 8'hFF, 4'd8, 0, 1, 0, 64'h0, 8'h00, 0));
    vt.push_back(mk(1, 64'hB7B6B5B4B3B2B1B0, 8'hFF, 4'd8, 0, 1, 1, 64'hA7A6A5A4A3A2A1A0, 8'hFF, 0));
    vt.push_back(mk(1, 64'hC7C6C5C4C3C2C1C0, 8'hFF, 4'd8, 1, 1, 1, 64'hB7B6B5B4B3B2B1B0, 8'hFF, 0));
    vt.push_back(mk(0, 64'h0, 8'h00, 4'd0, 0, 0, 1, 64'hC7C6C5C4C3C2C1C0, 8'hFF, 1));
    vt.push_back(mk(0, 64'h0, 8'h00, 4'd0, 0, 1, 0, 64'h0, 8'h00, 0));
    // Sparse mask 0x81, four beats.
    vt.push_back(mk(1, 64'h1716151413121110, 8'h81, 4'd2, 0, 1, 0, 64'h0, 8'h00, 0));
    vt.push_back(mk(1, 64'h1716151413121110, 8'h81, 4'd2, 0, 1, 0, 64'h0, 8'h00, 0));
    vt.push_back(mk(1, 64'h1716151413121110, 8'h81, 4'd2, 0, 1, 0, 64'h0, 8'h00, 0));
    vt.push_back(mk(1, 64'h1716151413121110, 8'h81, 4'd2, 1, 1, 0, 64'h0, 8'h00, 0));
    vt.push_back(mk(0, 64'h0, 8'h00, 4'd0, 0, 0, 1, 64'h1710171017101710, 8'hFF, 1));
    vt.push_back(mk(0, 64'h0, 8'h00, 4'd0, 0, 1, 0, 64'h0, 8'h00, 0));
    // Row spill 6 + 6.
    vt.push_back(mk(1, 64'h0706050403020100, 8'h3F, 4'd6, 0, 1, 0, 64'h0, 8'h00, 0));
    vt.push_back(mk(1, 64'h0F0E0D0C0B0A0908, 8'h3F, 4'd6, 1, 1, 0, 64'h0, 8'h00, 0));
    vt.push_back(mk(0, 64'h0, 8'h00, 4'd0, 0, 0, 1, 64'h0908050403020100, 8'hFF, 0));
    vt.push_back(mk(0, 64'h0, 8'h00, 4'd0, 0, 0, 1, 64'h000000000D0C0B0A, 8'h0F, 1));
    vt.push_back(mk(0, 64'h0, 8'h00, 4'd0, 0, 1, 0, 64'h0, 8'h00, 0));
    // Empty row.
    vt.push_back(mk(1, 64'hFFFFFFFFFFFFFFFF, 8'h00, 4'd0, 1, 1, 0, 64'h0, 8'h00, 0));
    vt.push_back(mk(0, 64'h0, 8'h00, 4'd0, 0, 0, 1, 64'h0, 8'h00, 1));
    vt.push_back(mk(0, 64'h0, 8'h00, 4'd0, 0, 1, 0, 64'h0, 8'h00, 0));

    foreach (vt[k]) begin
      cycle(vt[k].iv, vt[k].d, vt[k].m, vt[k].a, vt[k].l, vt[k].ordy, 1'b1);
      check($sformatf("vec%0d_in_ready", k), s_ir, vt[k].e_ir);
      check($sformatf("vec%0d_out_valid", k), s_ov, vt[k].e_ov);
      if (vt[k].e_ov) begin
        check($sformatf("vec%0d_out_data", k), s_d, vt[k].e_d);
        check($sformatf("vec%0d_out_keep", k), s_k, vt[k].e_k);
        check($sformatf("vec%0d_out_last", k), s_ol, vt[k].e_l);
      end
    end

    // Backpressure with a full word waiting.
    cycle(1'b1, 64'h3736353433323130, 8'hFF, 4'd8, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 64'h4746454443424140, 8'hFF, 4'd8, 1'b0, 1'b0, 1'b1);
      check("bp_in_ready", s_ir, 0);
      check("bp_out_valid", s_ov, 1);
      check("bp_out_data", s_d, 64'h3736353433323130);
    end
    cycle(1'b1, 64'h4746454443424140, 8'hFF, 4'd8, 1'b0, 1'b1, 1'b1);
    check("bp_release_in_ready", s_ir, 1);
    cycle(1'b1, 64'h0, 8'h00, 4'd0, 1'b1, 1'b1, 1'b1);
    check("bp_next_data", s_d, 64'h4746454443424140);
    idle(1'b1);
    check("bp_tail_last", s_ol, 1);
    check("bp_tail_keep", s_k, 0);
    idle(1'b1);

    // Amount disagreeing with mask, then reset mid-row.
    cycle(1'b1, 64'h5756555453525150, 8'h03, 4'd3, 1'b0, 1'b1, 1'b0);
    check("err_before", s_err, 0);
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      check("err_sticky", s_err, 1);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_keep", out_keep, 0);
    check("mid_rst_out_last", out_last, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_mismatch", mismatch_err, 0);
    @(negedge clk);
    reset = 1'b0;
    byte_q.delete();
    exp_q.delete();
    hold_prev = 1'b0;
    cycle(1'b1, 64'h6766656463626160, 8'hFF, 4'd8, 1'b1, 1'b1, 1'b1);
    idle(1'b1);
    check("post_rst_valid", s_ov, 1);
    check("post_rst_data", s_d, 64'h6766656463626160);
    check("post_rst_last", s_ol, 1);
    idle(1'b1);

    // Randomized traffic against the row model.
    for (int n = 0; n < 800; n++) begin
      bd = {$urandom(), $urandom()};
      bm = 8'($urandom());
      cycle(($urandom_range(0, 3) != 0), bd, bm, 4'($countones(bm)),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) != 0), 1'b1);
    end
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 50) begin
      cycle(1'b1, 64'h0, 8'h00, 4'd0, 1'b1, 1'b1, 1'b1);
      acc = s_ir;
      tries++;
    end
    check("final_beat_accepted", acc, 1);
    repeat (20) idle(1'b1);
    check("drain_empty", exp_q.size(), 0);
    check("drain_out_valid", s_ov, 0);
    check("no_spurious_err", s_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/column_packer.md
COLUMN_PACKER -- requirements
Module: column_packer

Interface
REQ-001 SHALL have parameter BYTES, default 8; byte lanes per input beat and per output word.
REQ-002 SHALL have parameter COUNT_SIZE, default 4; width of in_amount, which holds 0..BYTES.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, input beat valid.
REQ-006 SHALL have port in_ready, output, 1, input beat accepted when in_valid && in_ready.
REQ-007 SHALL have port in_data, input, 8*BYTES, beat bytes; lane i = bits [8i+7:8i].
REQ-008 SHALL have port in_mask, input, BYTES, column-select mask; bit i selects lane i.
REQ-009 SHALL have port in_amount, input, COUNT_SIZE, set-bit count of in_mask from the upstream popcount stage.
REQ-010 SHALL have port in_last, input, 1, final beat of the row.
REQ-011 SHALL have port out_valid, output, 1, output word valid.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts the word when out_valid && out_ready.
REQ-013 SHALL have port out_data, output, 8*BYTES, packed bytes.
REQ-014 SHALL have port out_keep, output, BYTES, valid-lane mask, always contiguous from lane 0.
REQ-015 SHALL have port out_last, output, 1, final word of the row.
REQ-016 SHALL have port mismatch_err, output, 1, sticky flag for an in_amount/in_mask disagreement.

Function
REQ-017 SHALL hold a staging buffer of 2*BYTES bytes and a level register lvl, range 0..2*BYTES-1.
REQ-018 SHALL append the selected lanes of each accepted beat at buffer positions lvl upward, in ascending lane order, and SHALL advance lvl by in_amount.
REQ-019 SHALL implement two states:
- ACCEPT: normal filling; moves to FLUSH when a beat is accepted with in_last=1.
- FLUSH: drains the buffered row; returns to ACCEPT on the pop that carries out_last=1.
REQ-020 SHALL drive in_ready = (state==ACCEPT) && (lvl<BYTES || out_ready); in_ready depends combinationally on out_ready.
REQ-021 SHALL assert out_valid when lvl>=BYTES, or when state==FLUSH (including lvl==0).
REQ-022 SHALL present buffer bytes 0..BYTES-1 on out_data.
REQ-023 SHALL drive out_keep as all ones when lvl>=BYTES, otherwise as the lowest lvl bits set.
REQ-024 SHALL drive data bytes with keep=0 to 0x00.
REQ-025 SHALL assert out_last only in FLUSH with lvl<=BYTES.
REQ-026 On a pop, SHALL shift the buffer down by BYTES and set lvl = max(lvl-BYTES, 0); an out_last pop SHALL set lvl=0.
REQ-027 On a simultaneous pop and push in one cycle, SHALL apply the pop first, then append at the post-pop level; the new lvl SHALL always be < 2*BYTES.
REQ-028 While out_valid=1 and out_ready=0, SHALL hold out_data, out_keep and out_last stable.
REQ-029 SHALL sustain one beat per cycle in each direction when out_ready=1 and masks are full.
REQ-030 SHALL use in_amount, not an internal recount, for the lvl update.
REQ-031 SHALL set mismatch_err one cycle after an accepted beat whose in_amount != popcount(in_mask); the flag holds until reset.
REQ-032 When a beat with in_last=1 and an empty mask is accepted with lvl==0, SHALL emit one word with out_keep=0 and out_last=1.
REQ-033 When lvl exactly equals BYTES at flush, SHALL emit a single full word with out_last=1.

Reset
REQ-034 While reset=1, SHALL immediately force: state ACCEPT, lvl=0, buffer zero, out_valid=0, out_last=0, out_keep=0, mismatch_err=0, in_ready=1.
REQ-035 SHALL discard a partially packed row on reset; the first beat after reset release starts a new row.

Verification (BYTES=8; full masks are 0xFF, amount 8)
REQ-036 Full masks: three beats 0xFF/8, last on the third, out_ready=1 -> three words keep 0xFF, out_last only on word 3, in_ready=1 throughout.
REQ-037 Sparse mask: four beats mask 0x81/amount 2, in_data bytes 0x10..0x17, last on beat 4 -> one word 10,17,10,17,10,17,10,17, keep 0xFF, out_last=1.
REQ-038 Row spill: 0x3F/6 then 0x3F/6 with last -> word 1 keep 0xFF out_last=0, word 2 keep 0x0F out_last=1, bytes in order.
REQ-039 Empty row: mask 0x00/0 with last at lvl 0 -> one word keep 0x00, data 0, out_last=1.
REQ-040 Backpressure: out_ready=0 with lvl>=8 -> in_ready=0 and out_data stable for 5 cycles; release -> word popped, input resumes the same cycle.
REQ-041 Error and reset: beat mask 0x03 with amount 3 -> mismatch_err=1 next cycle and sticky; reset asserted mid-row -> all outputs at reset values, mismatch_err=0.
